// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
//
// Round-robin arbiter that lets NUM_REQ requesters share the write port of a
// FIFO. Once a requester is granted, it keeps the port for up to BURST_MAX
// writes. The grant is released early if its request drops. One IDLE cycle
// separates successive grants, and that cycle performs the arbitration.
//
// Ports
//   wclk      in   write-domain clock
//   wrst_n    in   asynchronous active-low reset
//   req       in   per-requester write request (held while data is pending)
//   req_data  in   packed data, slice i belongs to requester i
//   full      in   FIFO full flag; blocks writes while high
//   w_en      out  FIFO write enable
//   w_data    out  FIFO write data (zero while idle)
//   gnt       out  registered one-hot owner, zero while idle
//   ack       out  combinational one-hot; marks the cycle the owner's word is written
//   busy      out  high while a grant is held
// -----------------------------------------------------------------------------
module fifo_wr_arbiter #(
   parameter int DATA_WIDTH = 8,
   parameter int NUM_REQ    = 4,
   parameter int BURST_MAX  = 4
) (
   input  logic                          wclk,
   input  logic                          wrst_n,
   input  logic [NUM_REQ-1:0]            req,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   input  logic                          full,
   output logic                          w_en,
   output logic [DATA_WIDTH-1:0]         w_data,
   output logic [NUM_REQ-1:0]            gnt,
   output logic [NUM_REQ-1:0]            ack,
   output logic                          busy
);

   localparam int IW = $clog2(NUM_REQ);
   localparam int CW = $clog2(BURST_MAX) + 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(BURST_MAX - 1);
   localparam logic [IW:0]   NREQ     = (IW+1)'(NUM_REQ);
   localparam logic [IW-1:0] TOP_IDX  = IW'(NUM_REQ - 1);

   typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

   state_t              state_q;
   logic [IW-1:0]       owner_q;
   logic [IW-1:0]       ptr_q;
   logic [CW-1:0]       cnt_q;
   logic [NUM_REQ-1:0]  gnt_q;

   logic [IW-1:0]       ptr_d;
   logic [CW-1:0]       cnt_d;
   logic [IW-1:0]       pick_idx;
   logic                pick_vld;
   logic                owner_req;
   logic                wr;
   logic                rel;

   logic [DATA_WIDTH-1:0] slice [NUM_REQ];

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
      assign slice[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
   end

   // Round-robin pick: scan from the pointer upward with wrap-around. The loop
   // runs from the farthest offset down so that the nearest set bit wins.
   always_comb begin
      logic [IW:0] sum;
      sum      = '0;
      pick_idx = '0;
      pick_vld = 1'b0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         sum = {1'b0, ptr_q} + (IW+1)'(k);
         if (sum >= NREQ) begin
            sum = sum - NREQ;
         end
         if (req[sum[IW-1:0]]) begin
            pick_idx = sum[IW-1:0];
            pick_vld = 1'b1;
         end
      end
   end

   assign owner_req = req[owner_q];
   assign wr        = (state_q == GRANT) && owner_req && !full;
   assign cnt_d     = cnt_q + 1'b1;
   assign ptr_d     = (owner_q == TOP_IDX) ? '0 : owner_q + 1'b1;
   // Release on the last write of a burst, or as soon as the owner withdraws.
   // The owner can withdraw even while full holds the write back.
   assign rel       = !owner_req || (wr && (cnt_q == LAST_CNT));

   assign w_en   = wr;
   assign ack    = wr ? (NUM_REQ'(1) << owner_q) : '0;
   assign w_data = (state_q == GRANT) ? slice[owner_q] : '0;
   assign gnt    = gnt_q;
   assign busy   = (state_q == GRANT);

   always_ff @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n) begin
         state_q <= IDLE;
         owner_q <= '0;
         ptr_q   <= '0;
         cnt_q   <= '0;
         gnt_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (pick_vld) begin
                  state_q <= GRANT;
                  owner_q <= pick_idx;
                  gnt_q   <= NUM_REQ'(1) << pick_idx;
                  cnt_q   <= '0;
               end
            end
            GRANT: begin
               if (rel) begin
                  state_q <= IDLE;
                  gnt_q   <= '0;
                  ptr_q   <= ptr_d;
                  cnt_q   <= '0;
               end else if (wr) begin
                  cnt_q   <= cnt_d;
               end
            end
            default: begin
               state_q <= IDLE;
               gnt_q   <= '0;
            end
         endcase
      end
   end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of each requester data bus and of w_data.
REQ-002 Parameter NUM_REQ, default 4: number of write requesters, legal range 2..8.
REQ-003 Parameter BURST_MAX, default 4: maximum writes per grant, legal range 1..16.
REQ-004 wclk  input  1  write-domain clock; all state changes on rising edge.
REQ-005 wrst_n  input  1  asynchronous active-low reset.
REQ-006 req  input  NUM_REQ  per-requester write request; bit i held high while requester i has data.
REQ-007 req_data  input  NUM_REQ*DATA_WIDTH  packed data; slice i belongs to requester i, stable while req[i]=1 and ack[i]=0.
REQ-008 full  input  1  FIFO write-side full flag.
REQ-009 w_en  output  1  FIFO write enable.
REQ-010 w_data  output  DATA_WIDTH  FIFO write data.
REQ-011 gnt  output  NUM_REQ  one-hot current owner, registered; all zero when idle.
REQ-012 ack  output  NUM_REQ  one-hot, combinational; ack[i]=1 marks the cycle requester i's word is written.
REQ-013 busy  output  1  high while a grant is held.

Function
REQ-014 Two states, IDLE and GRANT; state, owner index, round-robin pointer and burst counter registered.
REQ-015 IDLE: if any req bit set, select the first set bit searching upward from pointer with wrap-around; next cycle GRANT, gnt one-hot at that index, burst counter 0.
REQ-016 IDLE with req all zero: remain IDLE, gnt=0, w_en=0.
REQ-017 GRANT: w_en = req[owner] AND NOT full; ack[owner] = w_en; w_data = slice owner of req_data.
REQ-018 w_data = req_data slice of owner in GRANT, all zeros in IDLE.
REQ-019 Each write increments the burst counter; counter width ceil(log2(BURST_MAX))+1, no overflow.
REQ-020 Release from GRANT to IDLE when (write occurs and counter = BURST_MAX-1) or req[owner]=0; pointer set to (owner+1) mod NUM_REQ on release.
REQ-021 full=1 in GRANT: no write, no ack, counter held, grant held while req[owner]=1.
REQ-022 req[owner] dropping while full=1: release per REQ-020, no write.
REQ-023 Requests from non-owners never produce ack or w_en; they wait for arbitration in IDLE.
REQ-024 Arbitration cost: one IDLE cycle between successive grants; write latency from req rising (IDLE, not full) to first ack = 1 cycle.
REQ-025 At most one ack bit and at most one gnt bit high in any cycle; w_en = OR of ack.
REQ-026 BURST_MAX=1: every grant releases after its single write.

Reset
REQ-027 wrst_n low asynchronously forces state IDLE, gnt=0, pointer=0, counter=0; w_en, ack, busy low immediately.
REQ-028 Reset asserted mid-burst abandons the burst; no write issued in the reset cycle; first grant after release starts from requester 0.
REQ-029 After wrst_n rises, first grant no earlier than first rising edge of wclk with req nonzero.

Verification
REQ-030 Reset, req=4'b0001, full=0, data0=8'hA0..A5 -> gnt=0001 one cycle later, four acks writing A0,A1,A2,A3, then IDLE, regrant, remaining words.
REQ-031 req=4'b1111 held, full=0 -> grant order 0,1,2,3,0; four writes each, one idle cycle between grants.
REQ-032 req=4'b0010 granted, full pulsed high 3 cycles after 2nd write -> w_en=0 for those 3 cycles, gnt held, burst resumes and ends after 4 total writes.
REQ-033 Owner 2 drops req after 1 write while req[3]=1 -> release, pointer=3, requester 3 granted next.
REQ-034 wrst_n pulsed low mid-burst of requester 1 -> outputs zero same cycle; after release with req=4'b0011, requester 0 granted first.
REQ-035 Integration with async FIFO (depth 8, wclk 10 ns, rclk 14 ns, reader enabled) -> every acked word read out once, in ack order, no writes while full=1.
